// File: rtl/result_requant_drain_if.sv
// Bundle between the systolic array result port and the row consumer.
// The result_requant_drain block connects through the slave view.
interface result_requant_drain_if #(
    parameter int N       = 7,
    parameter int SHIFT_W = 5
);
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0][N-1:0][31:0] i_c;
    logic                      i_validResult;
    logic [SHIFT_W-1:0]        i_shift;
    logic [N-1:0][7:0]         o_row;
    logic [IDX_W-1:0]          o_rowIdx;
    logic                      o_valid;
    logic                      i_ready;
    logic                      o_last;
    logic                      o_busy;
    logic                      o_dropped;

    modport slave (
        input  i_c, i_validResult, i_shift, i_ready,
        output o_row, o_rowIdx, o_valid, o_last, o_busy, o_dropped
    );

    modport master (
        output i_c, i_validResult, i_shift, i_ready,
        input  o_row, o_rowIdx, o_valid, o_last, o_busy, o_dropped
    );
endinterface

// File: rtl/result_requant_drain.sv
// Captures an N x N int32 result matrix and drains it one requantized int8 row
// per accepted transfer, with rounding right shift and saturation on the selected row.
module result_requant_drain #(
    parameter int N       = 7,
    parameter int SHIFT_W = 5
) (
    input  logic                 i_clk,
    input  logic                 i_arst,
    result_requant_drain_if.slave bus
);
    localparam int               IDX_W    = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(N - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t             state_reg, state_next;
    logic [IDX_W-1:0]   row_reg, row_next;
    logic               dropped_reg, dropped_next;
    logic [31:0]        c_reg [N][N];
    logic [SHIFT_W-1:0] shift_reg;

    logic       valid;
    logic       last_row;
    logic       transfer;
    logic       capture;
    logic [7:0] q_row [N];

    assign valid    = (state_reg == DRAIN);
    assign last_row = (row_reg == LAST_ROW);
    assign transfer = valid && bus.i_ready;
    // New data is taken when idle, or exactly as the last row leaves so there is no bubble.
    assign capture  = !i_arst && bus.i_validResult && (!valid || (transfer && last_row));

    always_ff @(posedge i_clk) begin
        if (i_arst) begin
            state_reg   <= IDLE;
            row_reg     <= '0;
            dropped_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            row_reg     <= row_next;
            dropped_reg <= dropped_next;
        end
    end

    // Matrix and shift hold their value until the next accepted capture; no reset needed.
    always_ff @(posedge i_clk) begin
        if (capture) begin
            shift_reg <= bus.i_shift;
            for (int r = 0; r < N; r++) begin
                for (int k = 0; k < N; k++) begin
                    c_reg[r][k] <= bus.i_c[r][k];
                end
            end
        end
    end

    always_comb begin
        state_next   = state_reg;
        row_next     = row_reg;
        dropped_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (capture) begin
                    state_next = DRAIN;
                    row_next   = '0;
                end
            end
            DRAIN: begin
                if (capture) begin
                    row_next = '0;
                end else if (transfer) begin
                    if (last_row) begin
                        state_next = IDLE;
                        row_next   = '0;
                    end else begin
                        row_next = row_reg + IDX_W'(1);
                    end
                end
                dropped_next = bus.i_validResult && !capture;
            end
            default: begin
                state_next = IDLE;
                row_next   = '0;
            end
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_requant
            logic [31:0]        c_sel;
            logic signed [32:0] x_ext;
            logic signed [32:0] bias;
            logic signed [32:0] sum;
            logic signed [32:0] y;
            logic [7:0]         y_sat;

            // 33-bit sum keeps x + 2^(s-1) from wrapping at the int32 limits.
            always_comb begin
                c_sel = c_reg[row_reg][gi];
                x_ext = $signed({c_sel[31], c_sel});
                bias  = (shift_reg == '0) ? 33'sd0 : (33'sd1 <<< (shift_reg - SHIFT_W'(1)));
                sum   = x_ext + bias;
                y     = sum >>> shift_reg;
                if (y > 33'sd127) begin
                    y_sat = 8'h7F;
                end else if (y < -33'sd128) begin
                    y_sat = 8'h80;
                end else begin
                    y_sat = y[7:0];
                end
            end

            assign q_row[gi] = y_sat;
        end
    endgenerate

    always_comb begin
        bus.o_valid   = valid;
        bus.o_busy    = valid;
        bus.o_last    = valid && last_row;
        bus.o_rowIdx  = valid ? row_reg : '0;
        bus.o_dropped = dropped_reg;
        for (int k = 0; k < N; k++) begin
            bus.o_row[k] = valid ? q_row[k] : 8'h00;
        end
    end
endmodule

// File: tb/tb_result_requant_drain.sv
// Directed bench for result_requant_drain: streaming, rounding/saturation,
// backpressure, overlapping captures, mid-drain reset and a matmul end-to-end case.
module tb_result_requant_drain;
    localparam int N       = 7;
    localparam int SHIFT_W = 5;

    typedef logic [N-1:0][7:0] row_t;

    logic clk = 1'b0;
    logic arst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    result_requant_drain_if #(.N(N), .SHIFT_W(SHIFT_W)) bus ();

    result_requant_drain #(.N(N), .SHIFT_W(SHIFT_W)) dut (
        .i_clk (clk),
        .i_arst(arst),
        .bus   (bus)
    );

    row_t got_row  [N];
    int   got_idx  [N];
    logic got_last [N];
    int   got_n;
    int   stall_err;
    int   used_cycles;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_seq_matrix(input int scale);
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                bus.i_c[i][j] = 32'(scale * (i * N + j + 1));
            end
        end
    endtask

    task automatic send(input logic [SHIFT_W-1:0] s);
        bus.i_shift       = s;
        bus.i_validResult = 1'b1;
        step();
        bus.i_validResult = 1'b0;
    endtask

    function automatic row_t seq_row(input int r);
        row_t e;
        for (int j = 0; j < N; j++) e[j] = 8'(r * N + j + 1);
        return e;
    endfunction

    function automatic logic [7:0] ref_q(input longint v, input int s);
        longint q;
        longint fl;
        longint d;
        d  = longint'(1) << s;
        q  = (s == 0) ? v : v + (d / 2);
        fl = (q >= 0) ? q / d : -((-q + d - 1) / d);
        if (fl > 127) return 8'h7F;
        if (fl < -128) return 8'h80;
        return 8'(fl);
    endfunction

    // Collects rows from the consumer side; mode 0 keeps ready high, mode 1 applies a stall pattern.
    task automatic drain(input int mode, input int max_cycles);
        row_t       hold_row;
        int         hold_idx;
        logic       hold_last;
        bit         stalled;
        logic       rdy;
        logic [7:0] pat;
        pat         = 8'b0110_1001;
        got_n       = 0;
        stall_err   = 0;
        used_cycles = 0;
        stalled     = 1'b0;
        hold_row    = '0;
        hold_idx    = 0;
        hold_last   = 1'b0;
        while (used_cycles < max_cycles && got_n < N) begin
            rdy = (mode == 0) ? 1'b1 : pat[used_cycles % 8];
            bus.i_ready = rdy;
            if (bus.o_valid === 1'b1) begin
                if (stalled && (bus.o_row !== hold_row || int'(bus.o_rowIdx) != hold_idx
                                || bus.o_last !== hold_last))
                    stall_err++;
                if (rdy) begin
                    got_row[got_n]  = bus.o_row;
                    got_idx[got_n]  = int'(bus.o_rowIdx);
                    got_last[got_n] = bus.o_last;
                    $display("  xfer idx=%0d row=%h last=%0b", bus.o_rowIdx, bus.o_row, bus.o_last);
                    got_n++;
                    stalled = 1'b0;
                end else begin
                    stalled   = 1'b1;
                    hold_row  = bus.o_row;
                    hold_idx  = int'(bus.o_rowIdx);
                    hold_last = bus.o_last;
                end
            end
            step();
            used_cycles++;
        end
        bus.i_ready = 1'b1;
    endtask

    task automatic test_reset();
        arst = 1'b1;
        set_seq_matrix(1);
        bus.i_shift       = '0;
        bus.i_ready       = 1'b1;
        bus.i_validResult = 1'b1;
        step();
        step();
        arst = 1'b0;
        bus.i_validResult = 1'b0;
        checks++;
        if (bus.o_valid !== 1'b0 || bus.o_busy !== 1'b0 || bus.o_last !== 1'b0 || bus.o_dropped !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags got valid=%b busy=%b last=%b dropped=%b exp all 0",
                     bus.o_valid, bus.o_busy, bus.o_last, bus.o_dropped);
        end
        checks++;
        if (bus.o_row !== '0 || bus.o_rowIdx !== '0) begin
            failures++;
            $display("FAIL reset_data got row=%h idx=%0d exp 0", bus.o_row, bus.o_rowIdx);
        end
        step();
        checks++;
        if (bus.o_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_ignores_valid got valid=%b exp 0", bus.o_valid);
        end
    endtask

    task automatic test_stream();
        set_seq_matrix(1);
        bus.i_ready = 1'b1;
        send(0);
        checks++;
        if (bus.o_valid !== 1'b1 || bus.o_busy !== 1'b1) begin
            failures++;
            $display("FAIL stream_latency got valid=%b busy=%b exp 1", bus.o_valid, bus.o_busy);
        end
        drain(0, 50);
        checks++;
        if (got_n != N || used_cycles != N) begin
            failures++;
            $display("FAIL stream_count got rows=%0d cycles=%0d exp %0d", got_n, used_cycles, N);
        end
        for (int r = 0; r < got_n; r++) begin
            checks++;
            if (got_idx[r] != r || got_row[r] !== seq_row(r) || got_last[r] !== (r == N - 1)) begin
                failures++;
                $display("FAIL stream_row%0d got idx=%0d row=%h last=%b exp idx=%0d row=%h",
                         r, got_idx[r], got_row[r], got_last[r], r, seq_row(r));
            end
        end
        checks++;
        if (bus.o_busy !== 1'b0 || bus.o_valid !== 1'b0) begin
            failures++;
            $display("FAIL stream_idle_after got busy=%b valid=%b exp 0", bus.o_busy, bus.o_valid);
        end
    endtask

    task automatic test_rounding();
        row_t e;
        bus.i_c = '0;
        bus.i_c[0][0] = 32'sd5;
        bus.i_c[0][1] = 32'sd6;
        bus.i_c[0][2] = -32'sd6;
        bus.i_c[0][3] = 32'sd1000;
        bus.i_c[0][4] = -32'sd1000;
        bus.i_c[0][5] = -32'sd2;
        bus.i_c[0][6] = 32'sd2;
        send(2);
        drain(0, 50);
        e[0] = 8'h01; e[1] = 8'h02; e[2] = 8'hFF; e[3] = 8'h7F;
        e[4] = 8'h80; e[5] = 8'h00; e[6] = 8'h01;
        checks++;
        if (got_n != N || got_row[0] !== e) begin
            failures++;
            $display("FAIL round_shift2 got n=%0d row=%h exp row=%h", got_n, got_row[0], e);
        end
        checks++;
        if (got_row[1] !== '0) begin
            failures++;
            $display("FAIL round_zero_row got row=%h exp 0", got_row[1]);
        end
        bus.i_c = '0;
        bus.i_c[0][0] = 32'h7FFF_FFFF;
        bus.i_c[0][1] = 32'h8000_0000;
        bus.i_c[0][2] = 32'h4000_0000;
        bus.i_c[0][3] = 32'h3FFF_FFFF;
        bus.i_c[0][4] = 32'hFFFF_FFFF;
        send(31);
        bus.i_shift = '0;
        drain(0, 50);
        e = '0;
        e[0] = 8'h01; e[1] = 8'hFF; e[2] = 8'h01;
        checks++;
        if (got_n != N || got_row[0] !== e) begin
            failures++;
            $display("FAIL round_shift31 got n=%0d row=%h exp row=%h", got_n, got_row[0], e);
        end
    endtask

    task automatic test_backpressure();
        set_seq_matrix(1);
        send(0);
        drain(1, 200);
        checks++;
        if (got_n != N || stall_err != 0 || used_cycles <= N) begin
            failures++;
            $display("FAIL bp_summary got rows=%0d stall_err=%0d cycles=%0d exp rows=%0d stall_err=0 cycles>%0d",
                     got_n, stall_err, used_cycles, N, N);
        end
        for (int r = 0; r < got_n; r++) begin
            checks++;
            if (got_idx[r] != r || got_row[r] !== seq_row(r)) begin
                failures++;
                $display("FAIL bp_row%0d got idx=%0d row=%h exp idx=%0d row=%h",
                         r, got_idx[r], got_row[r], r, seq_row(r));
            end
        end
    endtask

    task automatic test_overlap();
        row_t e0;
        row_t e1;
        e0[0] = 8'hFF; e0[1] = 8'hFD; e0[2] = 8'hFC; e0[3] = 8'hFA;
        e0[4] = 8'hF9; e0[5] = 8'hF7; e0[6] = 8'hF6;
        e1[0] = 8'hF4; e1[1] = 8'hF3; e1[2] = 8'hF1; e1[3] = 8'hF0;
        e1[4] = 8'hEE; e1[5] = 8'hED; e1[6] = 8'hEB;
        bus.i_ready = 1'b1;
        set_seq_matrix(1);
        send(0);
        step();
        step();
        step();
        checks++;
        if (int'(bus.o_rowIdx) != 3) begin
            failures++;
            $display("FAIL ovl_at_row3 got idx=%0d exp 3", bus.o_rowIdx);
        end
        for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) bus.i_c[i][j] = 32'd100;
        send(0);
        checks++;
        if (bus.o_dropped !== 1'b1 || int'(bus.o_rowIdx) != 4 || bus.o_row !== seq_row(4)) begin
            failures++;
            $display("FAIL ovl_drop got dropped=%b idx=%0d row=%h exp dropped=1 idx=4 row=%h",
                     bus.o_dropped, bus.o_rowIdx, bus.o_row, seq_row(4));
        end
        step();
        checks++;
        if (bus.o_dropped !== 1'b0 || bus.o_row !== seq_row(5)) begin
            failures++;
            $display("FAIL ovl_drop_once got dropped=%b row=%h exp dropped=0 row=%h",
                     bus.o_dropped, bus.o_row, seq_row(5));
        end
        step();
        checks++;
        if (bus.o_last !== 1'b1 || bus.o_row !== seq_row(6)) begin
            failures++;
            $display("FAIL ovl_last got last=%b row=%h exp last=1 row=%h", bus.o_last, bus.o_row, seq_row(6));
        end
        set_seq_matrix(-3);
        send(1);
        checks++;
        if (bus.o_valid !== 1'b1 || int'(bus.o_rowIdx) != 0 || bus.o_row !== e0 || bus.o_dropped !== 1'b0) begin
            failures++;
            $display("FAIL ovl_chain got valid=%b idx=%0d row=%h dropped=%b exp valid=1 idx=0 row=%h dropped=0",
                     bus.o_valid, bus.o_rowIdx, bus.o_row, bus.o_dropped, e0);
        end
        drain(0, 50);
        checks++;
        if (got_n != N || got_row[1] !== e1) begin
            failures++;
            $display("FAIL ovl_new_matrix got n=%0d row1=%h exp n=%0d row1=%h", got_n, got_row[1], N, e1);
        end
    endtask

    task automatic test_reset_mid();
        row_t e0;
        e0[0] = 8'hFF; e0[1] = 8'hFD; e0[2] = 8'hFC; e0[3] = 8'hFA;
        e0[4] = 8'hF9; e0[5] = 8'hF7; e0[6] = 8'hF6;
        bus.i_ready = 1'b1;
        set_seq_matrix(1);
        send(0);
        step();
        step();
        step();
        checks++;
        if (int'(bus.o_rowIdx) != 3) begin
            failures++;
            $display("FAIL rstmid_pos got idx=%0d exp 3", bus.o_rowIdx);
        end
        arst = 1'b1;
        step();
        arst = 1'b0;
        checks++;
        if (bus.o_valid !== 1'b0 || bus.o_busy !== 1'b0 || bus.o_last !== 1'b0 || bus.o_row !== '0
            || bus.o_rowIdx !== '0 || bus.o_dropped !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_outputs got valid=%b busy=%b last=%b row=%h idx=%0d dropped=%b exp all 0",
                     bus.o_valid, bus.o_busy, bus.o_last, bus.o_row, bus.o_rowIdx, bus.o_dropped);
        end
        step();
        step();
        checks++;
        if (bus.o_valid !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_abandon got valid=%b exp 0", bus.o_valid);
        end
        set_seq_matrix(-3);
        send(1);
        checks++;
        if (bus.o_valid !== 1'b1 || int'(bus.o_rowIdx) != 0 || bus.o_row !== e0) begin
            failures++;
            $display("FAIL rstmid_restart got valid=%b idx=%0d row=%h exp valid=1 idx=0 row=%h",
                     bus.o_valid, bus.o_rowIdx, bus.o_row, e0);
        end
        drain(0, 50);
        checks++;
        if (got_n != N) begin
            failures++;
            $display("FAIL rstmid_drain got rows=%0d exp %0d", got_n, N);
        end
    endtask

    task automatic test_end_to_end();
        longint cm [N][N];
        row_t   e;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                cm[i][j] = 0;
                for (int k = 0; k < N; k++)
                    cm[i][j] += longint'(i * N + k + 1) * longint'((k + 1) * (j + 1));
                bus.i_c[i][j] = 32'(cm[i][j]);
            end
        end
        send(8);
        drain(0, 50);
        checks++;
        if (got_n != N) begin
            failures++;
            $display("FAIL e2e_count got rows=%0d exp %0d", got_n, N);
        end
        for (int r = 0; r < got_n; r++) begin
            for (int j = 0; j < N; j++) e[j] = ref_q(cm[r][j], 8);
            checks++;
            if (got_row[r] !== e) begin
                failures++;
                $display("FAIL e2e_row%0d got row=%h exp row=%h", r, got_row[r], e);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        arst              = 1'b1;
        bus.i_c           = '0;
        bus.i_validResult = 1'b0;
        bus.i_shift       = '0;
        bus.i_ready       = 1'b1;
        test_reset();
        test_stream();
        test_rounding();
        test_backpressure();
        test_overlap();
        test_reset_mid();
        test_end_to_end();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/result_requant_drain.md
RESULT_REQUANT_DRAIN -- requirements
Module: result_requant_drain

Interface
REQ-001 Parameter N, default 7: systolic array dimension; the result matrix is N x N.
REQ-002 Parameter SHIFT_W, default 5: width of the requantization shift amount.
REQ-003 i_clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 i_arst  input  1  synchronous, active-high reset, sampled on the i_clk rising edge.
REQ-005 i_c  input  [N-1:0][N-1:0][31:0]  array result matrix; row-major; each element is a signed two's-complement accumulator.
REQ-006 i_validResult  input  1  one-cycle pulse; i_c is valid in that cycle.
REQ-007 i_shift  input  SHIFT_W  arithmetic right-shift amount, 0..31; sampled with i_c.
REQ-008 o_row  output  [N-1:0][7:0]  one requantized row; signed int8 per element.
REQ-009 o_rowIdx  output  $clog2(N)  index of the row on o_row.
REQ-010 o_valid  output  1  o_row is valid.
REQ-011 i_ready  input  1  the consumer accepts o_row; a transfer occurs when o_valid and i_ready are both 1.
REQ-012 o_last  output  1  high with o_valid when o_rowIdx == N-1.
REQ-013 o_busy  output  1  a captured matrix is still draining.
REQ-014 o_dropped  output  1  one-cycle pulse: i_validResult was refused.

Function
REQ-015 The FSM SHALL have two states: IDLE and DRAIN.
REQ-016 In IDLE, i_validResult=1 SHALL capture i_c and i_shift into internal registers, clear the row counter, and enter DRAIN on the next edge.
REQ-017 In DRAIN, o_valid and o_busy SHALL be 1, and o_row/o_rowIdx SHALL present the row selected by the row counter; output latency is 1 cycle from capture to the first o_valid.
REQ-018 On a transfer, the row counter SHALL increment; o_row, o_rowIdx and o_last SHALL stay stable while o_valid=1 and i_ready=0.
REQ-019 A transfer with o_last=1 SHALL return the FSM to IDLE, with o_valid=0 next cycle, unless REQ-020 applies.
REQ-020 If i_validResult=1 in the same cycle as a transfer with o_last=1, the new matrix SHALL be captured and the FSM SHALL stay in DRAIN with row 0 of the new matrix next cycle (no bubble).
REQ-021 i_validResult=1 in DRAIN, other than under REQ-020, SHALL be ignored: captured data stays unchanged and o_dropped=1 for the next cycle.
REQ-022 Requantization per element x with shift s: s=0 gives y=x; s>0 gives y=(x + 2^(s-1)) >>> s, computed in 33-bit signed arithmetic with no wrap (round half up).
REQ-023 y SHALL saturate to [-128, 127] before driving o_row.
REQ-024 Requantization SHALL be combinational from the captured registers; only the selected row needs datapath logic.
REQ-025 Changes on i_shift outside a capture cycle SHALL have no effect.

Reset
REQ-026 While i_arst=1 at an edge, the FSM SHALL go to IDLE, the row counter to 0, and o_valid, o_busy, o_last, o_dropped to 0; o_row and o_rowIdx SHALL read 0.
REQ-027 A reset in the middle of DRAIN SHALL abandon the matrix; no further rows are emitted.
REQ-028 i_validResult in the same cycle as i_arst=1 SHALL be ignored.
REQ-029 The captured data registers need no reset; outputs SHALL be gated to 0 when not valid.

Verification
REQ-030 Case 1, N=7, i_ready tied 1, i_c[i][j]=i*7+j+1, shift 0 -> 7 consecutive valid rows, idx 0..6, values 1..49, o_last on idx 6, o_busy low the cycle after.
REQ-031 Case 2, rounding and saturation, shift 2, elements {5, 6, -6, 1000, -1000} -> {1, 2, -1, 127, -128}; also 0x7FFFFFFF with shift 31 -> 1, with no overflow.
REQ-032 Case 3, backpressure, i_ready toggled 1-0-0-1 pseudo-randomly -> each row held stable while stalled; exactly 7 transfers in order; no duplicates or skips.
REQ-033 Case 4, overlap: a second i_validResult during row 3 -> o_dropped pulses once and the first matrix completes unchanged; a third i_validResult coincident with the last-row transfer -> row 0 of the new matrix the next cycle.
REQ-034 Case 5, reset: i_arst asserted after row 2 transfers -> all outputs 0 next cycle; a later i_validResult restarts at row 0 with the new data.
REQ-035 Case 6, end-to-end: drive from the systolic array with A[i][j]=i*7+j+1 and B[i][j]=(i+1)*(j+1), shift 8 -> each o_row element equals sat8(round(C[i][j]/256)) from a software reference model.
